// File: rtl/sift_pkg.sv
// sift_pkg: shared DoG types, reader FSM state encodings and coordinate sizing.
package sift_pkg;
  localparam int DOG_WIDTH = 9;
  typedef logic signed [DOG_WIDTH-1:0] dog_t;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2;
  function automatic int coord_w(input int dim);
    return $clog2(dim);
  endfunction
endpackage

// File: rtl/cand_fifo.sv
// cand_fifo: synchronous candidate FIFO; head reads as zero while empty.
module cand_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 13
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign dout_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/dog_candidate_reader.sv
// dog_candidate_reader: raster-scans a DoG BRAM and streams pixels whose magnitude exceeds THRESHOLD.
module dog_candidate_reader
  import sift_pkg::*;
#(
  parameter int DIMENSION = 64,
  parameter int THRESHOLD = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_in,
  input  logic                                bram_ready,
  output logic [2*coord_w(DIMENSION)-1:0]     dog_addr,
  input  logic [DOG_WIDTH-1:0]                dog_data,
  output logic [coord_w(DIMENSION)-1:0]       cand_x,
  output logic [coord_w(DIMENSION)-1:0]       cand_y,
  output logic [DOG_WIDTH-1:0]                cand_val,
  output logic                                cand_valid,
  input  logic                                cand_ready,
  output logic                                bram_release,
  output logic                                done,
  output logic [2*coord_w(DIMENSION):0]       cand_count
);
  localparam int CW = coord_w(DIMENSION);
  localparam int AW = 2 * CW;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, a1_q, a2_q;
  logic [AW:0] count_q, count_d;
  logic v1_q, v2_q, rel_q, rel_d;
  logic [FW-1:0] fcnt;
  logic [FW:0] used;
  logic fempty, ffull, issue, push, pop;
  logic signed [9:0] v10;
  logic [9:0] mag;
  logic [AW+DOG_WIDTH-1:0] head;
  cand_fifo #(.DEPTH(FIFO_DEPTH), .W(AW + DOG_WIDTH)) u_fifo (
    .clk(clk), .rst_ni(rst_in), .push_i(push), .pop_i(pop), .din_i({a2_q, dog_data}),
    .dout_o(head), .full_o(ffull), .empty_o(fempty), .count_o(fcnt)
  );
  // Reads still in the pipe hold a FIFO slot in reserve, so a return can never overflow it.
  always_comb begin
    used = (FW+1)'(fcnt) + (FW+1)'(v1_q) + (FW+1)'(v2_q);
    issue = state_q == SCAN && !ffull && used < (FW+1)'(FIFO_DEPTH);
    v10 = 10'(dog_t'(dog_data));
    mag = v10 < 0 ? 10'(-v10) : 10'(v10);
    push = v2_q && mag > 10'(THRESHOLD);
    pop = !fempty && cand_ready;
    bram_release = state_q == DRAIN && !v1_q && !v2_q && !rel_q;
    done = state_q == DRAIN && (rel_q || bram_release) && fempty;
    rel_d = state_q == DRAIN ? rel_q | bram_release : 1'b0;
    addr_d = state_q == IDLE ? '0 : addr_q + AW'(issue);
    count_d = (state_q == IDLE && bram_ready) ? '0 : count_q + (AW+1)'(pop);
    state_d = (state_q == IDLE && bram_ready) ? SCAN :
              (state_q == SCAN && issue && addr_q == '1) ? DRAIN :
              done ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      rel_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      a1_q <= addr_q;
      a2_q <= a1_q;
      v1_q <= issue;
      v2_q <= v1_q;
      rel_q <= rel_d;
      count_q <= count_d;
    end
  end
  assign dog_addr = addr_q;
  assign cand_valid = !fempty;
  assign {cand_y, cand_x, cand_val} = head;
  assign cand_count = count_q;
endmodule

// File: tb/tb_dog_candidate_reader.sv
// tb_dog_candidate_reader: directed checks of the DoG candidate reader at DIMENSION=4.
module tb_dog_candidate_reader;
  logic clk = 0, rst_in = 0, bram_ready = 0, cand_ready = 1;
  logic [3:0] dog_addr;
  logic [8:0] dog_data, d1;
  logic [1:0] cand_x, cand_y;
  logic [8:0] cand_val;
  logic cand_valid, bram_release, done;
  logic [4:0] cand_count;
  logic signed [8:0] mem [16];
  logic [12:0] got [$];
  logic [12:0] exp_q [$];
  logic [3:0] prev_addr = 0;
  int errors = 0, checks = 0, cyc = 0, reads = 0, rel_n = 0, done_n = 0, rel_cyc = 0, done_cyc = 0;

  dog_candidate_reader #(.DIMENSION(4), .THRESHOLD(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_in(rst_in), .bram_ready(bram_ready), .dog_addr(dog_addr), .dog_data(dog_data),
    .cand_x(cand_x), .cand_y(cand_y), .cand_val(cand_val), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .bram_release(bram_release), .done(done), .cand_count(cand_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= mem[dog_addr];
    dog_data <= d1;
  end
  always @(negedge clk) begin
    cyc++;
    if (rst_in) begin
      if (cand_valid && cand_ready) got.push_back({cand_x, cand_y, cand_val});
      if (dog_addr != prev_addr) reads++;
      if (bram_release) begin rel_n++; rel_cyc = cyc; end
      if (done) begin done_n++; done_cyc = cyc; end
    end
    prev_addr = dog_addr;
  end

  function automatic logic [12:0] ent(input int x, input int y, input int v);
    return {2'(x), 2'(y), 9'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    got.delete();
    reads = 0; rel_n = 0; done_n = 0; rel_cyc = 0; done_cyc = 0;
    bram_ready = 1;
    tick();
    bram_ready = 0;
  endtask

  task automatic wait_done(input bit rnd);
    for (int i = 0; i < 1000 && done_n == 0; i++) begin
      tick();
      if (rnd) begin
        cand_ready = 1'($urandom);
        bram_ready = $urandom_range(0, 3) == 0;
      end
    end
    bram_ready = 0;
    cand_ready = 1;
    tick(); tick();
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) mem[i] = 9'(v);
  endtask

  task automatic test_reset();
    rst_in = 0;
    tick(); tick();
    checks++; if (dog_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", dog_addr); end
    checks++; if ({cand_valid, cand_x, cand_y, cand_val} !== 14'd0) begin errors++; $display("FAIL reset_cand: got %h expected 0", {cand_valid, cand_x, cand_y, cand_val}); end
    checks++; if ({bram_release, done, cand_count} !== 7'd0) begin errors++; $display("FAIL reset_ctl: got %h expected 0", {bram_release, done, cand_count}); end
    rst_in = 1;
    tick();
  endtask

  task automatic test_zeros();
    fill(0);
    start_frame();
    wait_done(0);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL zeros_cands: got %0d expected 0", got.size()); end
    checks++; if (reads !== 16) begin errors++; $display("FAIL zeros_reads: got %0d expected 16", reads); end
    checks++; if (rel_n !== 1 || done_n !== 1) begin errors++; $display("FAIL zeros_pulses: got rel=%0d done=%0d expected 1 1", rel_n, done_n); end
    checks++; if (rel_cyc > done_cyc) begin errors++; $display("FAIL zeros_order: got rel@%0d done@%0d expected rel first", rel_cyc, done_cyc); end
    checks++; if (cand_count !== 5'd0) begin errors++; $display("FAIL zeros_count: got %0d expected 0", cand_count); end
  endtask

  task automatic test_threshold();
    fill(0);
    mem[1] = 9; mem[14] = -9; mem[15] = 8;
    start_frame();
    wait_done(0);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL thr_size: got %0d expected 2", got.size()); end
    else begin
      checks++; if (got[0] !== ent(1, 0, 9)) begin errors++; $display("FAIL thr_c0: got %h expected %h", got[0], ent(1, 0, 9)); end
      checks++; if (got[1] !== ent(2, 3, -9)) begin errors++; $display("FAIL thr_c1: got %h expected %h", got[1], ent(2, 3, -9)); end
    end
    checks++; if (cand_count !== 5'd2) begin errors++; $display("FAIL thr_count: got %0d expected 2", cand_count); end
  endtask

  task automatic test_neg256();
    fill(0);
    mem[0] = -256;
    start_frame();
    wait_done(0);
    checks++; if (got.size() !== 1 || got[0] !== ent(0, 0, -256)) begin errors++; $display("FAIL neg256: got n=%0d %h expected n=1 %h", got.size(), got.size() ? got[0] : 13'h0, ent(0, 0, -256)); end
    checks++; if (cand_count !== 5'd1) begin errors++; $display("FAIL neg256_count: got %0d expected 1", cand_count); end
  endtask

  task automatic test_back_to_back();
    fill(100);
    cand_ready = 0;
    start_frame();
    for (int i = 0; i < 40; i++) tick();
    checks++; if (dog_addr !== 4'd4) begin errors++; $display("FAIL bp_stall_addr: got %0d expected 4", dog_addr); end
    checks++; if ({cand_valid, cand_x, cand_y, cand_val} !== {1'b1, ent(0, 0, 100)}) begin errors++; $display("FAIL bp_head: got %h expected %h", {cand_valid, cand_x, cand_y, cand_val}, {1'b1, ent(0, 0, 100)}); end
    checks++; if (rel_n !== 0) begin errors++; $display("FAIL bp_early_release: got %0d expected 0", rel_n); end
    cand_ready = 1;
    wait_done(0);
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL bp_size: got %0d expected 16", got.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== ent(i % 4, i / 4, 100)) begin errors++; $display("FAIL bp_c%0d: got %h expected %h", i, got[i], ent(i % 4, i / 4, 100)); end
    end
    checks++; if (cand_count !== 5'd16) begin errors++; $display("FAIL bp_count: got %0d expected 16", cand_count); end
    checks++; if (rel_n !== 1 || done_n !== 1 || rel_cyc > done_cyc) begin errors++; $display("FAIL bp_order: got rel=%0d@%0d done=%0d@%0d expected release first", rel_n, rel_cyc, done_n, done_cyc); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
        mem[i] = $urandom_range(0, 1) ? 9'($urandom_range(0, 511)) : 9'(int'($urandom_range(0, 20)) - 10);
        if ((mem[i] < 0 ? -int'(mem[i]) : int'(mem[i])) > 8) exp_q.push_back(ent(i % 4, i / 4, int'(mem[i])));
      end
      start_frame();
      wait_done(1);
      checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_size: got %0d expected %0d", f, got.size(), exp_q.size()); end
      else for (int i = 0; i < got.size(); i++) begin
        checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_c%0d: got %h expected %h", f, i, got[i], exp_q[i]); end
      end
      checks++; if (cand_count !== 5'(exp_q.size()) || done_n !== 1 || reads !== 16) begin errors++; $display("FAIL rnd%0d_frame: got count=%0d done=%0d reads=%0d expected %0d 1 16", f, cand_count, done_n, reads, exp_q.size()); end
    end
  endtask

  task automatic test_reset_mid();
    fill(50);
    start_frame();
    for (int i = 0; i < 100 && dog_addr !== 4'd7; i++) tick();
    checks++; if (dog_addr !== 4'd7) begin errors++; $display("FAIL mid_reach7: got %0d expected 7", dog_addr); end
    rst_in = 0;
    tick();
    checks++; if ({dog_addr, cand_valid, cand_x, cand_y, cand_val, bram_release, done, cand_count} !== 25'd0) begin errors++; $display("FAIL mid_reset_outs: got %h expected 0", {dog_addr, cand_valid, cand_x, cand_y, cand_val, bram_release, done, cand_count}); end
    rst_in = 1;
    fill(0);
    mem[5] = 20;
    tick();
    start_frame();
    wait_done(0);
    checks++; if (got.size() !== 1 || got[0] !== ent(1, 1, 20)) begin errors++; $display("FAIL mid_fresh: got n=%0d %h expected n=1 %h", got.size(), got.size() ? got[0] : 13'h0, ent(1, 1, 20)); end
    checks++; if (reads !== 16 || rel_n !== 1 || done_n !== 1) begin errors++; $display("FAIL mid_frame: got reads=%0d rel=%0d done=%0d expected 16 1 1", reads, rel_n, done_n); end
  endtask

  initial begin
    fill(0);
    test_reset();
    test_zeros();
    test_threshold();
    test_neg256();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
